// File: rtl/sevenseg_matrix_scanner.sv
// Column-scanned seven-segment renderer for an 8-row LED matrix with frame-synchronous capture,
// per-slot dead time and 16-level PWM. Define SEVENSEG_SCANNER_DP_EN to render the decimal point.
module sevenseg_matrix_scanner #(
    parameter int NUM_DIGITS  = 1,
    parameter int STROBE_DIV  = 8192,
    parameter int DEAD_CYCLES = 2,
    localparam int NC = 4 * NUM_DIGITS,
    localparam int CW = (NC > 1) ? $clog2(NC) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [8*NUM_DIGITS-1:0] seg_n,
    input  logic [3:0]              brightness,
    input  logic                    enable,
    output logic [7:0]              row_n,
    output logic [NC-1:0]           col_n,
    output logic [CW-1:0]           col_idx,
    output logic                    frame_start
);

    localparam int SW = $clog2(STROBE_DIV);
    localparam logic [SW-1:0] SLOT_LAST = SW'(STROBE_DIV - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(NC - 1);

    logic [SW-1:0]           slot_cnt;
    logic [CW-1:0]           col_cnt;
    logic [7*NUM_DIGITS-1:0] seg_core;
    logic [NUM_DIGITS-1:0]   seg_dp;
    logic [7*NUM_DIGITS-1:0] shadow_seg;
    logic [3:0]              shadow_bright;
    logic                    load_shadow;
    logic                    dead_done;
    logic                    gate_open;
    logic [2:0]              digit_sel;
    logic [1:0]              local_col;
    logic [6:0]              cur_seg;
    logic [7:0]              lit;
    logic [7:0]              row_next;
    logic [NC-1:0]           col_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_split
            assign seg_core[7*gi +: 7] = seg_n[8*gi +: 7];
            assign seg_dp[gi]          = seg_n[8*gi + 7];
        end
    endgenerate

    // Shadows follow the inputs while idle, otherwise only on the last clock of a frame.
    assign load_shadow = !enable || (slot_cnt == SLOT_LAST && col_cnt == COL_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_seg    <= '1;
            shadow_bright <= 4'd0;
        end else if (load_shadow) begin
            shadow_seg    <= seg_core;
            shadow_bright <= brightness;
        end
    end

`ifdef SEVENSEG_SCANNER_DP_EN
    logic [NUM_DIGITS-1:0] shadow_dp;
    logic                  cur_dp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_dp <= '1;
        end else if (load_shadow) begin
            shadow_dp <= seg_dp;
        end
    end

    always_comb begin
        cur_dp = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (digit_sel == 3'(d)) begin
                cur_dp = shadow_dp[d];
            end
        end
    end
`else
    logic unused_dp;
    assign unused_dp = ^seg_dp;
`endif

    assign digit_sel = 3'(col_cnt >> 2);
    assign local_col = col_cnt[1:0];

    always_comb begin
        cur_seg = '1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (digit_sel == 3'(d)) begin
                cur_seg = shadow_seg[7*d +: 7];
            end
        end
    end

    generate
        if (DEAD_CYCLES == 0) begin : g_no_dead
            assign dead_done = 1'b1;
        end else begin : g_dead
            assign dead_done = (slot_cnt >= SW'(DEAD_CYCLES));
        end
    endgenerate

    // The top four bits of the slot counter form the PWM slice.
    assign gate_open = dead_done && (slot_cnt[SW-1 -: 4] <= shadow_bright);

    always_comb begin
        lit = 8'h00;
        case (local_col)
            2'd0: begin
                lit[2:1] = {2{~cur_seg[5]}};
                lit[5:4] = {2{~cur_seg[4]}};
            end
            2'd3: begin
                lit[2:1] = {2{~cur_seg[1]}};
                lit[5:4] = {2{~cur_seg[2]}};
`ifdef SEVENSEG_SCANNER_DP_EN
                lit[7]   = ~cur_dp;
`endif
            end
            default: begin
                lit[0] = ~cur_seg[0];
                lit[3] = ~cur_seg[6];
                lit[6] = ~cur_seg[3];
            end
        endcase
    end

    assign row_next = ~(lit & {8{gate_open}});
    assign col_next = ~(NC'(1) << col_cnt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt    <= '0;
            col_cnt     <= '0;
            row_n       <= 8'hFF;
            col_n       <= '1;
            col_idx     <= '0;
            frame_start <= 1'b0;
        end else if (!enable) begin
            slot_cnt    <= '0;
            col_cnt     <= '0;
            row_n       <= 8'hFF;
            col_n       <= '1;
            col_idx     <= '0;
            frame_start <= 1'b0;
        end else begin
            row_n       <= row_next;
            col_n       <= col_next;
            col_idx     <= col_cnt;
            frame_start <= (slot_cnt == '0) && (col_cnt == '0);
            if (slot_cnt == SLOT_LAST) begin
                slot_cnt <= '0;
                col_cnt  <= (col_cnt == COL_LAST) ? '0 : col_cnt + 1'b1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_matrix_scanner.sv
// Randomized bench for sevenseg_matrix_scanner (2 digits, 32-clock slots) against a
// time-based reference model that renders from a segment-to-pixel table.
`timescale 1ns/1ps
module tb_sevenseg_matrix_scanner;

    localparam int ND    = 2;
    localparam int SD    = 32;
    localparam int DC    = 2;
    localparam int NC    = 4 * ND;
    localparam int FRAME = SD * NC;
`ifdef SEVENSEG_SCANNER_DP_EN
    localparam bit DP_ON = 1'b1;
`else
    localparam bit DP_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [15:0]   seg_n = '1;
    logic [3:0]    brightness = 4'd0;
    logic          enable = 1'b0;
    logic [7:0]    row_n;
    logic [NC-1:0] col_n;
    logic [2:0]    col_idx;
    logic          frame_start;

    int vectors = 0;
    int miscompares = 0;

    // Reference state: enabled clocks since scan start plus the frame-captured inputs.
    int          t = 0;
    logic [15:0] m_seg = '1;
    logic [3:0]  m_bright = 4'd0;

    // Pixels of segments a..g, dp as (row, local column); dp's single pixel is listed twice.
    int pix_r [8][2] = '{'{0,0}, '{1,2}, '{4,5}, '{6,6}, '{4,5}, '{1,2}, '{3,3}, '{7,7}};
    int pix_c [8][2] = '{'{1,2}, '{3,3}, '{3,3}, '{1,2}, '{0,0}, '{0,0}, '{1,2}, '{3,3}};

    always #5 clk = ~clk;

    sevenseg_matrix_scanner #(
        .NUM_DIGITS (ND),
        .STROBE_DIV (SD),
        .DEAD_CYCLES(DC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .seg_n      (seg_n),
        .brightness (brightness),
        .enable     (enable),
        .row_n      (row_n),
        .col_n      (col_n),
        .col_idx    (col_idx),
        .frame_start(frame_start)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_rows(int col, int pos);
        logic [7:0] r;
        logic [7:0] digit;
        bit         gate;
        r     = 8'hFF;
        digit = 8'(m_seg >> (8 * (col / 4)));
        gate  = (pos >= DC) && (((pos * 16) / SD) <= int'(m_bright));
        for (int s = 0; s < 8; s++) begin
            if (s == 7 && !DP_ON) continue;
            if (!digit[s] && gate) begin
                for (int p = 0; p < 2; p++) begin
                    if (pix_c[s][p] == col % 4) r[pix_r[s][p]] = 1'b0;
                end
            end
        end
        return r;
    endfunction

    task automatic step();
        logic [7:0]    e_row;
        logic [NC-1:0] e_col;
        int            e_idx;
        bit            e_fs;
        int            col;
        int            pos;
        e_row = 8'hFF;
        e_col = '1;
        e_idx = 0;
        e_fs  = 1'b0;
        if (!enable) begin
            t        = 0;
            m_seg    = seg_n;
            m_bright = brightness;
        end else begin
            col   = (t / SD) % NC;
            pos   = t % SD;
            e_row = model_rows(col, pos);
            e_col = ~(NC'(1) << col);
            e_idx = col;
            e_fs  = ((t % FRAME) == 0);
            if (pos == SD - 1 && col == NC - 1) begin
                m_seg    = seg_n;
                m_bright = brightness;
            end
            t++;
        end
        @(posedge clk);
        #1;
        check_eq("row_n", row_n, e_row);
        check_eq("col_n", col_n, e_col);
        check_eq("col_idx", col_idx, e_idx);
        check_eq("frame_start", frame_start, e_fs);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        check_eq("rst_async_row_n", row_n, 8'hFF);
        check_eq("rst_async_col_n", col_n, {NC{1'b1}});
        check_eq("rst_async_frame_start", frame_start, 1'b0);
        @(posedge clk);
        #1;
        check_eq("rst_held_col_idx", col_idx, 3'd0);
        check_eq("rst_held_row_n", row_n, 8'hFF);
        @(negedge clk);
        reset    = 1'b0;
        t        = 0;
        m_seg    = '1;
        m_bright = 4'd0;
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_row_n", row_n, 8'hFF);
        check_eq("reset_col_n", col_n, {NC{1'b1}});
        check_eq("reset_col_idx", col_idx, 3'd0);
        check_eq("reset_frame_start", frame_start, 1'b0);
        @(negedge clk);
        reset      = 1'b0;
        enable     = 1'b1;
        seg_n      = 16'hF9C0;
        brightness = 4'd15;
        run(2 * FRAME + 5);
        $display("txn directed glyphs 1/0: seg_n=%h bright=%0d", seg_n, brightness);

        seg_n = 16'hF9FF;
        run(2 * FRAME);
        $display("txn digit1 only: seg_n=%h bright=%0d", seg_n, brightness);

        seg_n = 16'hC0C0;
        for (int b = 0; b < 3; b++) begin
            brightness = (b == 0) ? 4'd0 : (b == 1) ? 4'd1 : 4'd7;
            run(2 * FRAME);
            $display("txn brightness sweep: seg_n=%h bright=%0d", seg_n, brightness);
        end

        seg_n      = 16'h7F7F;
        brightness = 4'd15;
        run(2 * FRAME);
        $display("txn decimal point: seg_n=%h dp_en=%0b", seg_n, DP_ON);

        // Mid-frame change lands at column 2 and must wait for the next frame.
        seg_n = 16'hC0C0;
        run(FRAME + 2 * SD + 7);
        seg_n = 16'h8080;
        run(FRAME);
        $display("txn tearing: seg_n=%h", seg_n);

        for (int i = 0; i < 40; i++) begin
            seg_n      = 16'($urandom);
            brightness = 4'($urandom);
            enable     = ($urandom_range(0, 7) != 0);
            n          = $urandom_range(1, 400);
            run(n);
            if ($urandom_range(0, 9) == 0) async_reset();
            $display("txn random %0d: seg_n=%h bright=%0d en=%0b cycles=%0d", i, seg_n, brightness, enable, n);
        end

        enable = 1'b1;
        run(SD + 11);
        async_reset();
        run(FRAME + 3);
        $display("txn reset mid-slot and restart");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
